// File: rtl/mem_access_unit_if.sv
// Bundle between the EX/MEM slot, the data cache and writeback.
// The slave side is the memory access unit itself.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  in_valid;
    logic [6:0]            in_opcode;
    logic [2:0]            in_funct3;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [31:0]           in_store_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [3:0]            mem_req_wmask;
    logic [31:0]           mem_req_wdata;

    logic                  mem_resp_valid;
    logic [31:0]           mem_resp_data;

    logic                  stall;
    logic                  wb_load_valid;
    logic [31:0]           wb_load_data;
    logic                  misalign_err;

    modport slave (
        input  in_valid,
        input  in_opcode,
        input  in_funct3,
        input  in_addr,
        input  in_store_data,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data,
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_wmask,
        output mem_req_wdata,
        output stall,
        output wb_load_valid,
        output wb_load_data,
        output misalign_err
    );

    modport master (
        output in_valid,
        output in_opcode,
        output in_funct3,
        output in_addr,
        output in_store_data,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data,
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_wmask,
        input  mem_req_wdata,
        input  stall,
        input  wb_load_valid,
        input  wb_load_data,
        input  misalign_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: issues byte-masked cache requests for loads/stores
// and returns extended load data to writeback.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [0:0] {
        IDLE,
        WAIT_RESP
    } state_t;

    state_t      state_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        wb_valid_q;
    logic [31:0] wb_data_q;
    logic [31:0] wb_data_d;
    logic        err_q;

    logic        is_load;
    logic        is_store;
    logic        f3_ok;
    logic        aligned;
    logic        legal;
    logic [2:0]  f3;
    logic [1:0]  off;

    logic [31:0] shifted;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign f3  = bus.in_funct3;
    assign off = bus.in_addr[1:0];

    always_comb begin
        is_load  = bus.in_valid && (bus.in_opcode == OP_LOAD);
        is_store = bus.in_valid && (bus.in_opcode == OP_STORE);
        f3_ok    = 1'b0;
        unique case (1'b1)
            is_load:  f3_ok = (!f3[2] && f3[1:0] != 2'b11) ||
                              (f3[2] && !f3[1]);
            is_store: f3_ok = !f3[2] && f3[1:0] != 2'b11;
            default:  f3_ok = 1'b0;
        endcase
        aligned = 1'b0;
        unique case (f3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b0;
        endcase
        legal = f3_ok && aligned;
    end

    always_comb begin
        bus.mem_req_addr  = {bus.in_addr[ADDR_WIDTH-1:2], 2'b00};
        bus.mem_req_wmask = 4'b0000;
        bus.mem_req_wdata = bus.in_store_data;
        unique case (f3[1:0])
            2'b00: bus.mem_req_wdata = {4{bus.in_store_data[7:0]}};
            2'b01: bus.mem_req_wdata = {2{bus.in_store_data[15:0]}};
            default: bus.mem_req_wdata = bus.in_store_data;
        endcase
        if (is_store) begin
            unique case (f3[1:0])
                2'b00: bus.mem_req_wmask = 4'b0001 << off;
                2'b01: bus.mem_req_wmask = off[1] ? 4'b1100 : 4'b0011;
                default: bus.mem_req_wmask = 4'b1111;
            endcase
        end
    end

    always_comb begin
        bus.mem_req_valid = 1'b0;
        bus.stall         = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.mem_req_valid = legal;
                bus.stall = legal && (is_load || !bus.mem_req_ready);
            end
            WAIT_RESP: begin
                bus.stall = !bus.mem_resp_valid;
            end
            default: begin
                bus.mem_req_valid = 1'b0;
                bus.stall         = 1'b0;
            end
        endcase
    end

    always_comb begin
        shifted = bus.mem_resp_data >> {off_q, 3'b000};
        rbyte   = shifted[7:0];
        rhalf   = off_q[1] ? bus.mem_resp_data[31:16]
                           : bus.mem_resp_data[15:0];
        unique case (f3_q)
            3'b000:  wb_data_d = {{24{rbyte[7]}}, rbyte};
            3'b001:  wb_data_d = {{16{rhalf[15]}}, rhalf};
            3'b100:  wb_data_d = {24'h0, rbyte};
            3'b101:  wb_data_d = {16'h0, rhalf};
            default: wb_data_d = bus.mem_resp_data;
        endcase
    end

    // Pulses default low each cycle; a response only counts in WAIT_RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
            wb_valid_q <= 1'b0;
            wb_data_q  <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            err_q      <= (state_q == IDLE) &&
                          (is_load || is_store) && !legal;
            unique case (state_q)
                IDLE: begin
                    if (legal && is_load && bus.mem_req_ready) begin
                        f3_q    <= f3;
                        off_q   <= off;
                        state_q <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (bus.mem_resp_valid) begin
                        wb_data_q  <= wb_data_d;
                        wb_valid_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.wb_load_valid = wb_valid_q;
    assign bus.wb_load_data  = wb_data_q;
    assign bus.misalign_err  = err_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage block directly upstream of the writeback control logic.
- Takes load/store instructions from the EX/MEM pipeline register and issues byte-masked, lane-aligned requests to the data cache over a valid/ready handshake.
- Stalls the pipeline while a load is outstanding, then delivers the sign/zero-extended load result to writeback, registered and aligned with the WB stage.

Parameters:
ADDR_WIDTH, 32, data-memory byte-address width; data path fixed at 32 bits.

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  EX/MEM slot holds a valid instruction
in_opcode  input  7  instruction opcode
in_funct3  input  3  access size / signedness
in_addr  input  ADDR_WIDTH  effective byte address from ALU
in_store_data  input  32  rs2 value for stores
mem_req_valid  output  1  cache request valid
mem_req_ready  input  1  cache accepts request this cycle
mem_req_addr  output  ADDR_WIDTH  word-aligned address ({in_addr[ADDR_WIDTH-1:2],2'b00})
mem_req_wmask  output  4  byte write enables; 0000 = read
mem_req_wdata  output  32  lane-replicated store data
mem_resp_valid  input  1  load data returned
mem_resp_data  input  32  returned word
stall  output  1  freeze IF/EX/MEM registers
wb_load_valid  output  1  one-cycle pulse, load result valid
wb_load_data  output  32  extended load result
misalign_err  output  1  one-cycle pulse on misaligned or illegal access

Behaviour:
- Memory op = in_valid & (opcode 0000011 LOAD or 0100011 STORE); all other opcodes are ignored and produce no request and no stall.
- FSM states: IDLE and WAIT_RESP. Reset: state=IDLE; wb_load_valid=0, wb_load_data=0, misalign_err=0.
- Legality check:
  - Half access requires addr[0]=0; word access requires addr[1:0]=00.
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010.
  - An illegal or misaligned access issues no request and no stall, and pulses misalign_err the next cycle.
- IDLE, legal memory op:
  - mem_req_valid=1 combinationally; address, wmask and wdata driven the same cycle.
  - Store wmask: SB = 0001<<addr[1:0]; SH = 0011 when addr[1]=0, else 1100; SW = 1111.
  - Store wdata: SB replicates the byte x4, SH replicates the half x2, SW passes through unchanged.
  - Load wmask = 0000.
- Store: completes on the handshake cycle (valid&ready). stall = !mem_req_ready. No state change.
- Load: on handshake, latch funct3 and addr[1:0], go to WAIT_RESP. stall=1 during the handshake cycle and while not ready.
- WAIT_RESP:
  - mem_req_valid=0.
  - stall=1 until the cycle mem_resp_valid=1; stall=0 in that cycle.
  - Next edge: select byte or half by latched addr[1:0]; sign-extend for funct3 000/001, zero-extend for 100/101; word passes through.
  - Same edge: register the result into wb_load_data, pulse wb_load_valid, return to IDLE.
- wb_load_data holds its value until the next load completes.
- Request outputs must be stable while mem_req_valid=1 and ready=0; stall guarantees the inputs are stable.
- mem_resp_valid in IDLE is ignored.
- Request and response are never both accepted in one cycle; responses arrive at least 1 cycle after acceptance.
- Reset asserted in WAIT_RESP: return to IDLE, drop the pending load, ignore any late response, clear all pulses.
- A back-to-back memory op in the cycle after a load response is issued normally (zero bubble).

Test Plan:
- SB, addr=0x1003, data=0x000000AB, ready=1 -> same cycle wmask=1000, wdata=0xABABABAB, req addr=0x1000, stall=0.
- LH, addr=0x2002, ready=1, response 0x8001_7FFF after 3 cycles -> stall high 4 cycles, then wb_load_valid pulse with wb_load_data=0xFFFF8001. Repeat as LHU -> 0x00008001.
- SW, addr=0x10, ready held low 2 cycles -> stall=1 for 2 cycles with request outputs stable; handshake on the 3rd cycle; wmask=1111.
- LW, addr=0x5 -> no request, stall=0, misalign_err pulse next cycle. Also LD (funct3 011) -> misalign_err pulse.
- LB, addr=0x1, accepted, reset asserted in WAIT_RESP, then response arrives -> state IDLE, wb_load_valid never pulses, stall=0 after reset.
- LBU at 0x0 followed immediately by SH at 0x6, response 0x000000F0 -> wb_load_data=0x000000F0; SH requested the cycle after the response with wmask=1100.
